// File: rtl/muldiv.sv
// rtl/muldiv.sv - 32-bit iterative multiply/divide unit with HI/LO result registers
// One radix-2 step per clock; the fixed 34-cycle schedule does not depend on operand values.
module muldiv (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        wehi,
  input  logic        welo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic        isdiv;
  logic        sa;
  logic        sb;
  logic        bzero;
  logic [31:0] opnd;
  logic [63:0] acc;

  logic        nega;
  logic        negb;
  logic [31:0] maga;
  logic [31:0] magb;
  logic [32:0] madd;
  logic [63:0] mul_next;
  logic [32:0] dsh;
  logic [33:0] ddiff;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign nega = op[0] & srca[31];
  assign negb = op[0] & srcb[31];
  assign maga = nega ? -srca : srca;
  assign magb = negb ? -srcb : srcb;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}; opnd is the other operand
  assign madd     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {madd, acc[31:1]};

  assign dsh      = {acc[63:32], acc[31]};
  assign ddiff    = {1'b0, dsh} - {2'b00, opnd};
  assign div_next = ddiff[33] ? {dsh[31:0], acc[30:0], 1'b0}
                              : {ddiff[31:0], acc[30:0], 1'b1};

  assign prod = (sa ^ sb) ? -acc : acc;
  assign quo  = bzero ? 32'hFFFF_FFFF : ((sa ^ sb) ? -acc[31:0] : acc[31:0]);
  // remainder follows the dividend sign; for a zero divisor this restores srca exactly
  assign rem  = sa ? -acc[63:32] : acc[63:32];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 6'd0;
      isdiv <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      bzero <= 1'b0;
      opnd  <= 32'd0;
      acc   <= 64'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            isdiv <= op[1];
            sa    <= nega;
            sb    <= negb;
            bzero <= (srcb == 32'd0);
            cnt   <= 6'd0;
            opnd  <= op[1] ? magb : maga;
            acc   <= {32'd0, op[1] ? maga : magb};
            state <= CALC;
          end else begin
            if (wehi) hi <= srca;
            if (welo) lo <= srca;
          end
        end
        CALC: begin
          acc <= isdiv ? div_next : mul_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          hi    <= isdiv ? rem : prod[63:32];
          lo    <= isdiv ? quo : prod[31:0];
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - randomized scoreboard bench for muldiv against an arithmetic reference model
module tb_muldiv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] srca = 32'd0;
  logic [31:0] srcb = 32'd0;
  logic        wehi = 1'b0;
  logic        welo = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .wehi(wehi), .welo(welo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          c;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (o)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: return 64'(la * lb);
      2'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, on time
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_hi", hi, e.h);
        chk("done_lo", lo, e.l);
        chk("done_cycle", cyc, e.c);
      end
    end
  end

  task automatic wr(input logic wh, input logic wl, input logic [31:0] d);
    srca = d;
    wehi = wh;
    welo = wl;
    @(negedge clk);
    wehi = 1'b0;
    welo = 1'b0;
    if (wh) model_hi = d;
    if (wl) model_lo = d;
    chk("mt_hi", hi, model_hi);
    chk("mt_lo", lo, model_lo);
  endtask

  // Issues one op; abort_at>0 pulses reset at that busy cycle instead of completing
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int abort_at);
    logic [63:0] r;
    exp_t        e;
    logic        busy_bad;
    logic        hold_bad;
    r = model(o, a, b);
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    op = o; srca = a; srcb = b;
    start = 1'b1; wehi = 1'b1; welo = 1'b1;
    e.h = r[63:32];
    e.l = r[31:0];
    e.c = cyc + 34;
    sbq.push_back(e);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        start = 1'b0; wehi = 1'b0; welo = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        void'(sbq.pop_back());
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (k < 34 && (hi !== model_hi || lo !== model_lo)) hold_bad = 1'b1;
      if (k < 33) begin
        start = 1'($urandom_range(0, 1));
        wehi  = 1'($urandom_range(0, 1));
        welo  = 1'($urandom_range(0, 1));
        op    = 2'($urandom_range(0, 3));
        srca  = $urandom;
        srcb  = $urandom;
      end else begin
        start = 1'b0; wehi = 1'b0; welo = 1'b0;
      end
    end
    chk("busy_cycles_1_34_bad", {31'd0, busy_bad}, 32'd0);
    chk("hold_during_calc_bad", {31'd0, hold_bad}, 32'd0);
    model_hi = e.h;
    model_lo = e.l;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_hi", hi, model_hi);
    chk("idle_lo", lo, model_lo);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd1, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(2'd2, 32'd100, 32'd7, 0);
    run_op(2'd2, 32'h1234_5678, 32'd0, 0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd3, 32'h8765_4321, 32'd0, 0);
    wr(1'b1, 1'b0, 32'hA5A5_A5A5);
    wr(1'b0, 1'b1, 32'h5A5A_0F0F);
    wr(1'b1, 1'b1, 32'h0123_4567);
    run_op(2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 10);
    run_op(2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(ro, ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have no parameters; the operand and result width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 srca  input  32  operand A (multiplicand or dividend); also the mthi/mtlo write data.
REQ-007 srcb  input  32  operand B (multiplier or divisor).
REQ-008 wehi  input  1  mthi: write srca into hi.
REQ-009 welo  input  1  mtlo: write srca into lo.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse; hi and lo hold the new result in that cycle.
REQ-012 hi  output  32  HI register: upper product word, or remainder.
REQ-013 lo  output  32  LO register: lower product word, or quotient.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CALC, FIX and DONE.
REQ-015 IDLE, start=1 at edge E0: the block SHALL latch the operand magnitudes, op and the signs, clear the 6-bit counter, and go to CALC.
REQ-016 CALC SHALL perform one radix-2 iteration per edge: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 After the 32nd iteration (edge E0+32), the FSM SHALL go to FIX.
REQ-018 FIX at edge E0+33 SHALL apply the sign correction, write hi/lo, and go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle and return to IDLE at edge E0+34.
REQ-020 Latency SHALL be fixed at 34 cycles from the start edge to IDLE, regardless of operand values.
REQ-021 hi and lo SHALL NOT change during CALC or FIX; they SHALL hold their previous values until the FIX edge.
REQ-022 MULTU SHALL produce the unsigned 64-bit product {hi,lo} = srca*srcb.
REQ-023 MULT SHALL produce the two's-complement 64-bit product of the signed operands.
REQ-024 DIVU SHALL produce lo = srca/srcb and hi = srca%srcb, both unsigned.
REQ-025 DIV SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000 (wraps, no trap).
REQ-027 Division by zero (DIVU or DIV) SHALL give lo=0xFFFFFFFF and hi=srca, with the full 34-cycle timing.
REQ-028 start asserted while busy (CALC, FIX or DONE) SHALL be ignored; no queuing.
REQ-029 In IDLE with start=0, wehi/welo SHALL write srca into hi/lo at the edge; both may be set in the same cycle.
REQ-030 wehi/welo SHALL be ignored while busy.
REQ-031 In IDLE, start=1 SHALL take priority over wehi/welo; the writes in that cycle are dropped.
REQ-032 Operands and op SHALL be captured only at the start edge; later changes to srca, srcb and op SHALL NOT affect the result.

Reset
REQ-033 reset_n=0 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, busy=0, done=0, hi=0 and lo=0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no result written; the first start after release SHALL behave normally.
REQ-035 All internal operand and accumulator registers SHALL reset to 0.

Verification
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT 0xFFFFFFFE(-2)*0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for cycles 1-34.
REQ-038 DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU 100/7 -> lo=14, hi=2.
REQ-039 DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 wehi with srca=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5; the same wehi during CALC -> hi unchanged; start and welo in the same IDLE cycle -> lo not written, operation starts.
REQ-041 reset_n pulsed low at cycle 10 of a MULTU -> hi=lo=0, busy=0 immediately; no done pulse; a following start completes correctly.
